ama_riscv_fetch: RTL and testbench

Instruction fetch frontend: owns the PC, issues word requests to instruction memory, and presents one instruction at a time to the decoder on `inst_dec`. It consumes the decoder's `fe_ctrl` (`pc_sel`, `pc_we`) together with the ALU target to advance, stall or redirect. It keeps one outstanding memory request, a one-entry instruction buffer, and kill logic that discards responses from a stale fetch address.

---
 rtl/ama_riscv_fetch_if.sv | 32 +++
 rtl/ama_riscv_fetch.sv | 125 ++++++++++++
 tb/tb_ama_riscv_fetch.sv | 231 +++++++++++++++++++++++
 3 files changed

// File: rtl/ama_riscv_fetch_if.sv
// Shared fetch types and the instruction-memory request/response bundle
// between the fetch frontend (master) and the instruction memory (slave).
package ama_riscv_fetch_pkg;
   typedef enum logic {
      PC_SEL_INC4 = 1'b0,
      PC_SEL_ALU  = 1'b1
   } pc_sel_t;
endpackage

interface ama_riscv_fetch_if;
   logic        imem_req_valid;
   logic        imem_req_ready;
   logic [31:0] imem_req_addr;
   logic        imem_rsp_valid;
   logic [31:0] imem_rsp_data;

   modport master (
      output imem_req_valid,
      output imem_req_addr,
      input  imem_req_ready,
      input  imem_rsp_valid,
      input  imem_rsp_data
   );

   modport slave (
      input  imem_req_valid,
      input  imem_req_addr,
      output imem_req_ready,
      output imem_rsp_valid,
      output imem_rsp_data
   );
endinterface

// File: rtl/ama_riscv_fetch.sv
// Instruction fetch frontend: single outstanding imem request, one-entry
// instruction buffer towards decode, and kill of responses from stale addresses.
module ama_riscv_fetch
   import ama_riscv_fetch_pkg::*;
#(
   parameter logic [31:0] RESET_VECTOR = 32'h4000_0000,
   parameter logic [31:0] NOP_INST     = 32'h0000_0013
) (
   input  logic                     clk,
   input  logic                     rst,
   input  pc_sel_t                  pc_sel,
   input  logic                     pc_we,
   input  logic [31:0]              alu_out,
   ama_riscv_fetch_if.master        imem,
   output logic [31:0]              inst_dec,
   output logic                     inst_valid,
   output logic [31:0]              pc_dec
);

   typedef enum logic [1:0] {
      BOOT = 2'd0,
      REQ  = 2'd1,
      WAIT = 2'd2
   } state_t;

   state_t      state_reg, state_next;
   logic [31:0] pc_nxt_reg, pc_nxt_next;
   logic [31:0] acc_addr_reg, acc_addr_next;
   logic        kill_reg, kill_next;
   logic [31:0] inst_dec_reg, inst_dec_next;
   logic        inst_valid_reg, inst_valid_next;
   logic [31:0] pc_dec_reg, pc_dec_next;

   logic consume;
   logic redirect;
   logic req_valid;
   logic accept;
   logic rsp_wait;
   logic load;

   assign consume   = inst_valid_reg & pc_we;
   assign redirect  = consume & (pc_sel == PC_SEL_ALU);
   // Only request when the buffer will be free by the time the response lands.
   assign req_valid = (state_reg == REQ) & (~inst_valid_reg | consume);
   assign accept    = req_valid & imem.imem_req_ready;
   assign rsp_wait  = (state_reg == WAIT) & imem.imem_rsp_valid;
   assign load      = rsp_wait & ~kill_reg & ~redirect;

   assign imem.imem_req_valid = req_valid;
   assign imem.imem_req_addr  = pc_nxt_reg;

   assign inst_dec   = inst_dec_reg;
   assign inst_valid = inst_valid_reg;
   assign pc_dec     = pc_dec_reg;

   always_comb begin
      state_next = state_reg;
      unique case (state_reg)
         BOOT:    state_next = REQ;
         REQ:     if (accept) state_next = WAIT;
         WAIT:    if (imem.imem_rsp_valid) state_next = REQ;
         default: state_next = BOOT;
      endcase
   end

   always_comb begin
      pc_nxt_next   = pc_nxt_reg;
      acc_addr_next = acc_addr_reg;
      kill_next     = kill_reg;
      if (accept) begin
         acc_addr_next = pc_nxt_reg;
      end
      if (redirect) begin
         pc_nxt_next = {alu_out[31:2], 2'b00};
         // A response in this same cycle retires the old request, so only a
         // still-pending or freshly accepted request needs to be killed.
         kill_next   = ((state_reg == WAIT) & ~imem.imem_rsp_valid) | accept;
      end else begin
         if (accept) begin
            pc_nxt_next = pc_nxt_reg + 32'd4;
         end
         if (rsp_wait) begin
            kill_next = 1'b0;
         end
      end
   end

   always_comb begin
      inst_dec_next   = inst_dec_reg;
      inst_valid_next = inst_valid_reg;
      pc_dec_next     = pc_dec_reg;
      if (redirect) begin
         inst_dec_next   = NOP_INST;
         inst_valid_next = 1'b0;
      end else if (load) begin
         inst_dec_next   = imem.imem_rsp_data;
         inst_valid_next = 1'b1;
         pc_dec_next     = acc_addr_reg;
      end else if (consume) begin
         inst_dec_next   = NOP_INST;
         inst_valid_next = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_reg      <= BOOT;
         pc_nxt_reg     <= RESET_VECTOR;
         acc_addr_reg   <= RESET_VECTOR;
         kill_reg       <= 1'b0;
         inst_dec_reg   <= NOP_INST;
         inst_valid_reg <= 1'b0;
         pc_dec_reg     <= RESET_VECTOR;
      end else begin
         state_reg      <= state_next;
         pc_nxt_reg     <= pc_nxt_next;
         acc_addr_reg   <= acc_addr_next;
         kill_reg       <= kill_next;
         inst_dec_reg   <= inst_dec_next;
         inst_valid_reg <= inst_valid_next;
         pc_dec_reg     <= pc_dec_next;
      end
   end

endmodule

// File: tb/tb_ama_riscv_fetch.sv
// Bench for ama_riscv_fetch: directed cycle table, mid-request reset, then a
// randomized run checked against an architectural next-PC model.
module tb_ama_riscv_fetch;
   import ama_riscv_fetch_pkg::*;

   localparam logic [31:0] RV  = 32'h4000_0000;
   localparam logic [31:0] NOP = 32'h0000_0013;
   localparam int NVEC = 26;

   typedef struct packed {
      logic        we;
      logic        sel_alu;
      logic [31:0] alu;
      logic        rdy;
      logic        rv;
      logic [31:0] rd;
      logic        e_req_v;
      logic [31:0] e_addr;
      logic        e_iv;
      logic [31:0] e_inst;
      logic [31:0] e_pc;
   } vec_t;

   logic        clk;
   logic        rst;
   pc_sel_t     pc_sel;
   logic        pc_we;
   logic [31:0] alu_out;
   logic [31:0] inst_dec;
   logic        inst_valid;
   logic [31:0] pc_dec;

   ama_riscv_fetch_if imem();

   ama_riscv_fetch #(.RESET_VECTOR(RV), .NOP_INST(NOP)) dut (
      .clk        (clk),
      .rst        (rst),
      .pc_sel     (pc_sel),
      .pc_we      (pc_we),
      .alu_out    (alu_out),
      .imem       (imem),
      .inst_dec   (inst_dec),
      .inst_valid (inst_valid),
      .pc_dec     (pc_dec)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int   n_cmp  = 0;
   int   n_fail = 0;
   vec_t vecs[NVEC];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: actual %h required %h", name, act, exp);
      end
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_req_valid"}, {31'd0, imem.imem_req_valid}, 32'd0);
      check({tag, "_req_addr"}, imem.imem_req_addr, RV);
      check({tag, "_inst_valid"}, {31'd0, inst_valid}, 32'd0);
      check({tag, "_inst_dec"}, inst_dec, NOP);
      check({tag, "_pc_dec"}, pc_dec, RV);
   endtask

   task automatic set_vec(input int i, input logic we, input logic sa, input logic [31:0] alu,
                          input logic rdy, input logic rv, input logic [31:0] rd,
                          input logic erv, input logic [31:0] ea, input logic eiv,
                          input logic [31:0] ei, input logic [31:0] ep);
      vecs[i].we = we;  vecs[i].sel_alu = sa;  vecs[i].alu = alu;
      vecs[i].rdy = rdy; vecs[i].rv = rv;      vecs[i].rd = rd;
      vecs[i].e_req_v = erv; vecs[i].e_addr = ea; vecs[i].e_iv = eiv;
      vecs[i].e_inst = ei;   vecs[i].e_pc = ep;
   endtask

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      return (a * 32'd3) ^ 32'h5A5A_0013;
   endfunction

   // Random-phase state: memory responder and architectural PC model
   logic        pend;
   logic [31:0] pend_addr;
   int          pend_due;
   logic [31:0] exp_pc;
   int          delivered;
   int          idle_cycles;
   logic        hold_prev;
   logic [31:0] hold_addr;

   initial begin
      rst = 1'b0;
      pc_sel = PC_SEL_INC4;
      pc_we = 1'b0;
      alu_out = 32'd0;
      imem.imem_req_ready = 1'b0;
      imem.imem_rsp_valid = 1'b0;
      imem.imem_rsp_data = 32'd0;

      //        we sa alu           rdy rv rd            erv addr          iv inst          pc
      set_vec(0,  0, 0, 32'd0,        1, 0, 32'd0,        0, RV,           0, NOP,          RV);
      set_vec(1,  0, 0, 32'd0,        1, 0, 32'd0,        1, RV,           0, NOP,          RV);
      set_vec(2,  0, 0, 32'd0,        1, 1, 32'h0000_0093, 0, RV + 32'h4,  0, NOP,          RV);
      for (int i = 3; i <= 6; i++)
         set_vec(i, 0, 0, 32'd0,      1, 0, 32'd0,        0, RV + 32'h4,   1, 32'h0000_0093, RV);
      set_vec(7,  1, 0, 32'd0,        0, 0, 32'd0,        1, RV + 32'h4,   1, 32'h0000_0093, RV);
      for (int i = 8; i <= 11; i++)
         set_vec(i, 0, 0, 32'd0,      0, 0, 32'd0,        1, RV + 32'h4,   0, NOP,          RV);
      set_vec(12, 0, 0, 32'd0,        1, 0, 32'd0,        1, RV + 32'h4,   0, NOP,          RV);
      set_vec(13, 0, 0, 32'd0,        1, 0, 32'd0,        0, RV + 32'h8,   0, NOP,          RV);
      set_vec(14, 0, 0, 32'd0,        1, 1, 32'h0000_0113, 0, RV + 32'h8,  0, NOP,          RV);
      set_vec(15, 1, 0, 32'd0,        1, 0, 32'd0,        1, RV + 32'h8,   1, 32'h0000_0113, RV + 32'h4);
      set_vec(16, 0, 0, 32'd0,        1, 1, 32'h0000_0193, 0, RV + 32'hC,  0, NOP,          RV + 32'h4);
      set_vec(17, 1, 1, 32'h4000_0103, 1, 0, 32'd0,       1, RV + 32'hC,   1, 32'h0000_0193, RV + 32'h8);
      set_vec(18, 0, 0, 32'd0,        1, 1, 32'hDEAD_0001, 0, 32'h4000_0100, 0, NOP,        RV + 32'h8);
      set_vec(19, 0, 0, 32'd0,        1, 0, 32'd0,        1, 32'h4000_0100, 0, NOP,         RV + 32'h8);
      set_vec(20, 0, 0, 32'd0,        1, 1, 32'h0000_0213, 0, 32'h4000_0104, 0, NOP,        RV + 32'h8);
      set_vec(21, 1, 1, 32'h4000_0202, 0, 0, 32'd0,       1, 32'h4000_0104, 1, 32'h0000_0213, 32'h4000_0100);
      set_vec(22, 0, 0, 32'd0,        0, 1, 32'hBAD0_0000, 1, 32'h4000_0200, 0, NOP,        32'h4000_0100);
      set_vec(23, 0, 0, 32'd0,        1, 0, 32'd0,        1, 32'h4000_0200, 0, NOP,         32'h4000_0100);
      set_vec(24, 0, 0, 32'd0,        1, 1, 32'h0000_0293, 0, 32'h4000_0204, 0, NOP,        32'h4000_0100);
      set_vec(25, 0, 0, 32'd0,        1, 0, 32'd0,        0, 32'h4000_0204, 1, 32'h0000_0293, 32'h4000_0200);

      repeat (3) @(posedge clk);
      #1;
      check_reset_outputs("reset");

      for (int i = 0; i < NVEC; i++) begin
         @(negedge clk);
         rst = 1'b1;
         pc_we = vecs[i].we;
         pc_sel = vecs[i].sel_alu ? PC_SEL_ALU : PC_SEL_INC4;
         alu_out = vecs[i].alu;
         imem.imem_req_ready = vecs[i].rdy;
         imem.imem_rsp_valid = vecs[i].rv;
         imem.imem_rsp_data = vecs[i].rd;
         #1;
         check($sformatf("vec%0d_req_valid", i), {31'd0, imem.imem_req_valid}, {31'd0, vecs[i].e_req_v});
         check($sformatf("vec%0d_req_addr", i), imem.imem_req_addr, vecs[i].e_addr);
         check($sformatf("vec%0d_inst_valid", i), {31'd0, inst_valid}, {31'd0, vecs[i].e_iv});
         check($sformatf("vec%0d_inst_dec", i), inst_dec, vecs[i].e_inst);
         check($sformatf("vec%0d_pc_dec", i), pc_dec, vecs[i].e_pc);
         $display("vec %0d: req_valid=%0b addr=%h inst_valid=%0b inst=%h pc=%h",
                  i, imem.imem_req_valid, imem.imem_req_addr, inst_valid, inst_dec, pc_dec);
      end

      // Reset while a request is outstanding
      @(negedge clk);
      pc_we = 1'b1; pc_sel = PC_SEL_INC4; imem.imem_req_ready = 1'b1; imem.imem_rsp_valid = 1'b0;
      #1;
      check("midrst_accept_valid", {31'd0, imem.imem_req_valid}, 32'd1);
      check("midrst_accept_addr", imem.imem_req_addr, 32'h4000_0204);
      @(negedge clk);
      pc_we = 1'b0;
      #1;
      check("midrst_wait_valid", {31'd0, imem.imem_req_valid}, 32'd0);
      #1 rst = 1'b0;
      #1;
      check_reset_outputs("midrst");
      $display("mid-request reset: req_valid=%0b addr=%h inst_valid=%0b pc=%h",
               imem.imem_req_valid, imem.imem_req_addr, inst_valid, pc_dec);
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst = 1'b1;
      #1;
      check("restart_boot_valid", {31'd0, imem.imem_req_valid}, 32'd0);

      // Randomized run against the architectural model
      pend = 1'b0; pend_addr = 32'd0; pend_due = 0;
      exp_pc = RV; delivered = 0; idle_cycles = 0;
      hold_prev = 1'b0; hold_addr = 32'd0;
      for (int cyc = 0; cyc < 800; cyc++) begin
         logic will_redirect;
         @(negedge clk);
         pc_we = ($urandom_range(0, 3) != 0);
         pc_sel = ($urandom_range(0, 4) == 0) ? PC_SEL_ALU : PC_SEL_INC4;
         alu_out = RV + 32'($urandom_range(0, 4095));
         imem.imem_req_ready = ($urandom_range(0, 3) != 0);
         imem.imem_rsp_valid = 1'b0;
         imem.imem_rsp_data = 32'hBAD0_0000 | 32'(cyc);
         if (pend && cyc >= pend_due) begin
            imem.imem_rsp_valid = 1'b1;
            imem.imem_rsp_data = mem_word(pend_addr);
            pend = 1'b0;
         end else if (!pend && $urandom_range(0, 9) == 0) begin
            imem.imem_rsp_valid = 1'b1;
         end
         #1;
         if (cyc == 0) begin
            check("restart_req_valid", {31'd0, imem.imem_req_valid}, 32'd1);
            check("restart_req_addr", imem.imem_req_addr, RV);
         end
         if (!inst_valid) check("idle_inst_nop", inst_dec, NOP);
         if (pend) check("single_outstanding", {31'd0, imem.imem_req_valid}, 32'd0);
         if (hold_prev) begin
            check("bp_req_valid", {31'd0, imem.imem_req_valid}, 32'd1);
            check("bp_req_addr", imem.imem_req_addr, hold_addr);
         end
         will_redirect = inst_valid && pc_we && (pc_sel == PC_SEL_ALU);
         if (inst_valid && pc_we) begin
            check("deliver_pc", pc_dec, exp_pc);
            check("deliver_inst", inst_dec, mem_word(exp_pc));
            $display("deliver %0d: pc=%h inst=%h redirect=%0b", delivered, pc_dec, inst_dec, will_redirect);
            delivered++;
            idle_cycles = 0;
            exp_pc = will_redirect ? (alu_out & 32'hFFFF_FFFC) : exp_pc + 32'd4;
         end else begin
            idle_cycles++;
            if (idle_cycles > 40) begin
               check("progress_watchdog", 32'(idle_cycles), 32'd40);
               idle_cycles = 0;
            end
         end
         hold_prev = imem.imem_req_valid && !imem.imem_req_ready && !will_redirect;
         hold_addr = imem.imem_req_addr;
         if (imem.imem_req_valid && imem.imem_req_ready) begin
            pend = 1'b1;
            pend_addr = imem.imem_req_addr;
            pend_due = cyc + int'($urandom_range(1, 3));
         end
      end
      if (delivered < 100) check("delivered_count", 32'(delivered), 32'd100);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
